// File: rtl/motor_pwm_out.sv
// motor_pwm_out: sign-magnitude PWM output stage for the motor position loop.
// Samples the signed effort once per PWM frame, scales and clamps it to the
// frame length, and inserts a pwm-low dead interval on every direction reversal.
module motor_pwm_out #(
    parameter int PERIOD   = 1000,
    parameter int DEADTIME = 50,
    parameter int SHIFT    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] u_in,
    input  logic        enable,
    output logic        pwm,
    output logic        dir,
    output logic        period_start,
    output logic        sat
);

    // Counter, duty and dead-time counter share one width; it holds PERIOD itself.
    localparam int DW = $clog2(PERIOD + 1);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   duty_q, duty_d;
    logic [DW-1:0]   dead_q, dead_d;
    logic            dir_q, dir_d;
    logic            sat_q, sat_d;
    logic            pwm_q, pwm_d;
    logic            ps_q, ps_d;

    logic                sample;
    logic signed [31:0]  s;
    logic [32:0]         abs_s;
    logic                clamp;
    logic [DW-1:0]       mag;
    logic                mag_nz;
    logic                sgn;

    // Effort scaling: 33-bit magnitude so -2^31 negates without overflow.
    always_comb begin
        sample = (cnt_q == DW'(PERIOD - 1));
        s      = $signed(u_in) >>> SHIFT;
        abs_s  = s[31] ? (33'd0 - {s[31], s}) : {1'b0, s};
        clamp  = (abs_s > 33'(PERIOD));
        mag    = clamp ? DW'(PERIOD) : abs_s[DW-1:0];
        mag_nz = (mag != '0);
        sgn    = ~s[31] && (s != 32'sd0);
    end

    // Free-running frame counter, period strobe and registered gate drive.
    always_comb begin
        cnt_d = sample ? '0 : cnt_q + 1'b1;
        ps_d  = (cnt_q == '0);
        pwm_d = enable && (state_q == RUN) && (cnt_q < duty_q);
    end

    // Bridge FSM: duty/dir updates, dead-time sequencing, enable override.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        sat_d   = sat_q;
        if (sample)
            sat_d = clamp;
        if (!enable) begin
            state_d = IDLE;
            duty_d  = '0;
        end else begin
            if (sample)
                duty_d = mag;
            case (state_q)
                IDLE: begin
                    if (sample) begin
                        state_d = RUN;
                        if (mag_nz)
                            dir_d = sgn;
                    end
                end
                RUN: begin
                    if (sample && mag_nz && (sgn != dir_q)) begin
                        state_d = DEAD;
                        dead_d  = DW'(DEADTIME);
                    end
                end
                DEAD: begin
                    // A new sample that no longer asks for reversal cancels it.
                    if (sample && (!mag_nz || (sgn == dir_q))) begin
                        state_d = RUN;
                    end else if (dead_q == DW'(1)) begin
                        dir_d   = ~dir_q;
                        state_d = RUN;
                    end else begin
                        dead_d = dead_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            duty_q  <= '0;
            dead_q  <= '0;
            dir_q   <= 1'b0;
            sat_q   <= 1'b0;
            pwm_q   <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
            dir_q   <= dir_d;
            sat_q   <= sat_d;
            pwm_q   <= pwm_d;
            ps_q    <= ps_d;
        end
    end

    assign pwm          = pwm_q;
    assign dir          = dir_q;
    assign period_start = ps_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_motor_pwm_out.sv
// tb_motor_pwm_out: directed scenarios for the PWM output stage
// (PERIOD=100, DEADTIME=10, SHIFT=0).
module tb_motor_pwm_out;

    logic        clk;
    logic        reset;
    logic [31:0] u_in;
    logic        enable;
    logic        pwm;
    logic        dir;
    logic        period_start;
    logic        sat;

    int n_chk  = 0;
    int n_pass = 0;
    int viol   = 0;
    logic prev_dir = 1'b0;
    logic prev_pwm = 1'b0;

    motor_pwm_out #(.PERIOD(100), .DEADTIME(10), .SHIFT(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .u_in         (u_in),
        .enable       (enable),
        .pwm          (pwm),
        .dir          (dir),
        .period_start (period_start),
        .sat          (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle, sample 1 time unit after the edge, track dir/pwm overlap.
    task automatic step();
        @(posedge clk);
        #1;
        if ((dir !== prev_dir) && (pwm || prev_pwm))
            viol++;
        prev_dir = dir;
        prev_pwm = pwm;
    endtask

    // One PWM frame = 100 cycles starting with the period_start cycle.
    task automatic run_frame(output int hi, output int first, output int ps);
        hi = 0; first = -1; ps = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (pwm === 1'b1) begin
                hi++;
                if (first < 0) first = i;
            end
            if (period_start === 1'b1) ps++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        prev_dir = dir;
        prev_pwm = pwm;
        viol     = 0;
    endtask

    task automatic test_reset();
        enable = 1'b0; u_in = 32'd0; reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if ({pwm, dir, sat, period_start} !== 4'b0000) $display("FAIL reset_outs: got %b required 0000", {pwm, dir, sat, period_start}); else n_pass++;
        reset = 1'b0;
        step();
        n_chk++; if (period_start !== 1'b1) $display("FAIL reset_ps_first: got %b required 1", period_start); else n_pass++;
        step();
        n_chk++; if (period_start !== 1'b0) $display("FAIL reset_ps_one_cycle: got %b required 0", period_start); else n_pass++;
        n_chk++; if (pwm !== 1'b0) $display("FAIL reset_idle_pwm: got %b required 0", pwm); else n_pass++;
    endtask

    task automatic test_duty40();
        int hi, first, ps;
        enable = 1'b1; u_in = 32'd40;
        apply_reset();
        run_frame(hi, first, ps);
        n_chk++; if (hi !== 0) $display("FAIL d40_f0_hi: got %0d required 0", hi); else n_pass++;
        n_chk++; if (ps !== 1) $display("FAIL d40_f0_ps: got %0d required 1", ps); else n_pass++;
        for (int f = 1; f <= 2; f++) begin
            run_frame(hi, first, ps);
            n_chk++; if (hi !== 40) $display("FAIL d40_hi f%0d: got %0d required 40", f, hi); else n_pass++;
            n_chk++; if (first !== 0) $display("FAIL d40_first f%0d: got %0d required 0", f, first); else n_pass++;
            n_chk++; if (ps !== 1) $display("FAIL d40_ps f%0d: got %0d required 1", f, ps); else n_pass++;
        end
        n_chk++; if ({dir, sat} !== 2'b10) $display("FAIL d40_dir_sat: got %b required 10", {dir, sat}); else n_pass++;
    endtask

    task automatic test_saturation();
        int hi, first, ps;
        enable = 1'b1; u_in = 32'd250;
        apply_reset();
        run_frame(hi, first, ps);
        u_in = 32'h8000_0000;
        run_frame(hi, first, ps);
        n_chk++; if (hi !== 100) $display("FAIL satp_hi: got %0d required 100", hi); else n_pass++;
        n_chk++; if ({dir, sat} !== 2'b11) $display("FAIL satp_dir_sat: got %b required 11", {dir, sat}); else n_pass++;
        run_frame(hi, first, ps);
        n_chk++; if (first !== 10) $display("FAIL satn_gap: got %0d required 10", first); else n_pass++;
        n_chk++; if (hi !== 90) $display("FAIL satn_rev_hi: got %0d required 90", hi); else n_pass++;
        n_chk++; if ({dir, sat} !== 2'b01) $display("FAIL satn_dir_sat: got %b required 01", {dir, sat}); else n_pass++;
        run_frame(hi, first, ps);
        n_chk++; if (hi !== 100) $display("FAIL satn_hi: got %0d required 100", hi); else n_pass++;
        n_chk++; if (viol !== 0) $display("FAIL satn_overlap: got %0d required 0", viol); else n_pass++;
    endtask

    task automatic test_reversal();
        int hi, first, ps;
        enable = 1'b1; u_in = 32'd40;
        apply_reset();
        run_frame(hi, first, ps);
        u_in = -32'sd30;
        run_frame(hi, first, ps);
        n_chk++; if (hi !== 40) $display("FAIL rev_pre_hi: got %0d required 40", hi); else n_pass++;
        n_chk++; if (dir !== 1'b1) $display("FAIL rev_pre_dir: got %b required 1", dir); else n_pass++;
        run_frame(hi, first, ps);
        n_chk++; if (first !== 10) $display("FAIL rev_gap: got %0d required 10", first); else n_pass++;
        n_chk++; if (hi !== 20) $display("FAIL rev_hi: got %0d required 20", hi); else n_pass++;
        n_chk++; if (dir !== 1'b0) $display("FAIL rev_dir: got %b required 0", dir); else n_pass++;
        run_frame(hi, first, ps);
        n_chk++; if (hi !== 30) $display("FAIL rev_next_hi: got %0d required 30", hi); else n_pass++;
        n_chk++; if (first !== 0) $display("FAIL rev_next_first: got %0d required 0", first); else n_pass++;
        n_chk++; if (viol !== 0) $display("FAIL rev_overlap: got %0d required 0", viol); else n_pass++;
    endtask

    task automatic test_zero();
        int hi, first, ps;
        enable = 1'b1; u_in = 32'd40;
        apply_reset();
        run_frame(hi, first, ps);
        u_in = 32'd0;
        run_frame(hi, first, ps);
        u_in = 32'd20;
        run_frame(hi, first, ps);
        n_chk++; if (hi !== 0) $display("FAIL zero_hi: got %0d required 0", hi); else n_pass++;
        n_chk++; if (dir !== 1'b1) $display("FAIL zero_dir: got %b required 1", dir); else n_pass++;
        run_frame(hi, first, ps);
        n_chk++; if (hi !== 20) $display("FAIL zero_next_hi: got %0d required 20", hi); else n_pass++;
        n_chk++; if (first !== 0) $display("FAIL zero_no_gap: got %0d required 0", first); else n_pass++;
        n_chk++; if (viol !== 0) $display("FAIL zero_overlap: got %0d required 0", viol); else n_pass++;
    endtask

    task automatic test_enable();
        int hi, first, ps;
        enable = 1'b1; u_in = 32'd40;
        apply_reset();
        run_frame(hi, first, ps);
        repeat (15) step();
        n_chk++; if (pwm !== 1'b1) $display("FAIL en_pre_drop: got %b required 1", pwm); else n_pass++;
        enable = 1'b0; u_in = 32'd70;
        step();
        n_chk++; if (pwm !== 1'b0) $display("FAIL en_drop_next: got %b required 0", pwm); else n_pass++;
        hi = 0;
        repeat (34) begin step(); if (pwm === 1'b1) hi++; end
        enable = 1'b1;
        repeat (50) begin step(); if (pwm === 1'b1) hi++; end
        n_chk++; if (hi !== 0) $display("FAIL en_low_hi: got %0d required 0", hi); else n_pass++;
        run_frame(hi, first, ps);
        n_chk++; if (hi !== 70) $display("FAIL en_resume_hi: got %0d required 70", hi); else n_pass++;
        n_chk++; if (first !== 0) $display("FAIL en_resume_first: got %0d required 0", first); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int hi, first, ps;
        enable = 1'b1; u_in = 32'd250;
        apply_reset();
        run_frame(hi, first, ps);
        repeat (10) step();
        n_chk++; if ({pwm, dir, sat} !== 3'b111) $display("FAIL rm_pre: got %b required 111", {pwm, dir, sat}); else n_pass++;
        reset = 1'b1;
        #1;
        n_chk++; if ({pwm, dir, sat, period_start} !== 4'b0000) $display("FAIL rm_async: got %b required 0000", {pwm, dir, sat, period_start}); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        n_chk++; if (period_start !== 1'b1) $display("FAIL rm_ps_after: got %b required 1", period_start); else n_pass++;
        run_frame(hi, first, ps);
        n_chk++; if (ps !== 1) $display("FAIL rm_ps_frame: got %0d required 1", ps); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; u_in = 32'd0;
        test_reset();
        test_duty40();
        test_saturation();
        test_reversal();
        test_zero();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
